// File: rtl/pmem_arb_pkg.sv
// Shared types for the two-requester physical-memory arbiter.
// Holds the FSM state encoding, the requester identifiers and the bus widths.
package pmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

endpackage

// File: rtl/pmem_arb_rr.sv
// Two-way round-robin picker: a contested grant goes to whichever cache did not
// win last time; last_i records whether the I-cache took the most recent grant.
module pmem_arb_rr
  import pmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_pend,
  input  logic d_pend,
  input  logic take,
  output req_e grant,
  output logic last_i
);

  always_comb begin
    // NOTE: assign a default first so every path writes grant and no latch is inferred.
    grant = REQ_I;
    if (i_pend && d_pend) begin
      grant = last_i ? REQ_D : REQ_I;
    end else if (d_pend) begin
      grant = REQ_D;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      last_i <= 1'b0;
    end else if (take) begin
      last_i <= (grant == REQ_I);
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache line requests onto one cacheline adaptor.
// One grant per transaction; the FSM always returns to IDLE after a resp.
module pmem_arbiter
  import pmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_e state;
  state_e state_next;
  req_e   grant;
  logic   last_i;
  logic   i_pend;
  logic   d_pend;
  logic   take;

  assign i_pend = i_pmem_read || i_pmem_write;
  assign d_pend = d_pmem_read || d_pmem_write;
  assign take   = (state == IDLE) && (i_pend || d_pend) && !rst;

  // Read data is broadcast; only the resp pulse tells a cache the line is for it.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  pmem_arb_rr u_rr (
    .clk    (clk),
    .rst    (rst),
    .i_pend (i_pend),
    .d_pend (d_pend),
    .take   (take),
    .grant  (grant),
    .last_i (last_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state)
      IDLE: begin
        // A resp arriving here belongs to no grant and is dropped.
        if (i_pend || d_pend) begin
          state_next = (grant == REQ_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_write   = i_pmem_write;
        pmem_address = i_pmem_address;
        pmem_wdata   = i_pmem_wdata;
        i_pmem_resp  = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset abandons any grant immediately: nothing forwarded, no resp pulse.
    if (rst) begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
    end
  end

  a_i_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(i_pmem_read && i_pmem_write));
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: the bench plays both caches and the adaptor,
// each scenario task checks its own hand-computed expectations.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read, i_pmem_write;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_wdata, i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata, d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_write   (i_pmem_write),
    .i_pmem_address (i_pmem_address),
    .i_pmem_wdata   (i_pmem_wdata),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Plays the adaptor for one transaction: waits (bounded) for a request,
  // holds for lat cycles, pulses pmem_resp and retires the answered request.
  task automatic txn(input int lat, output int seen, output logic gi, output logic gd,
                     output logic rd, output logic wr, output logic [31:0] ad,
                     output logic [255:0] wd, output int ip, output int dp);
    seen = -1; ip = 0; dp = 0; gi = 1'b0; gd = 1'b0;
    rd = 1'b0; wr = 1'b0; ad = '0; wd = '0;
    #1;
    for (int c = 0; c < 20; c++) begin
      ip += int'(i_pmem_resp);
      dp += int'(d_pmem_resp);
      if (pmem_read || pmem_write) begin
        seen = c;
        break;
      end
      tick();
    end
    if (seen < 0) return;
    rd = pmem_read; wr = pmem_write; ad = pmem_address; wd = pmem_wdata;
    for (int c = 0; c < lat; c++) begin
      tick();
      ip += int'(i_pmem_resp);
      dp += int'(d_pmem_resp);
    end
    pmem_resp = 1'b1;
    #1;
    gi = i_pmem_resp; gd = d_pmem_resp;
    ip += int'(gi);
    dp += int'(gd);
    tick();
    pmem_resp = 1'b0;
    if (gi) begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; end
    if (gd) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    total++; if (dut.u_rr.last_i !== 1'b0) begin bad++; $display("FAIL reset_last_i: got %b want 0", dut.u_rr.last_i); end
    total++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
    total++; if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
      bad++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", pmem_address, pmem_wdata); end
  endtask

  task automatic test_single_read();
    int seen, ip, dp; logic gi, gd, rd, wr; logic [31:0] ad; logic [255:0] wd;
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    d_pmem_address = 32'hDEAD_0000;
    txn(5, seen, gi, gd, rd, wr, ad, wd, ip, dp);
    total++; if (seen !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", seen); end
    total++; if ({rd, wr} !== 2'b10) begin bad++; $display("FAIL single_rw: got %b want 10", {rd, wr}); end
    total++; if (ad !== 32'h0000_1000) begin bad++; $display("FAIL single_addr: got %h want 00001000", ad); end
    total++; if (ip !== 1) begin bad++; $display("FAIL single_i_pulses: got %0d want 1", ip); end
    total++; if (dp !== 0) begin bad++; $display("FAIL single_d_pulses: got %0d want 0", dp); end
    total++; if (dut.state !== IDLE || pmem_read !== 1'b0) begin
      bad++; $display("FAIL single_after: got state=%0d rd=%b want 0/0", dut.state, pmem_read); end
  endtask

  task automatic test_contested();
    int seen, ip, dp; logic gi, gd, rd, wr; logic [31:0] ad; logic [255:0] wd;
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    txn(2, seen, gi, gd, rd, wr, ad, wd, ip, dp);
    total++; if ({gi, gd} !== 2'b10 || ad !== 32'h0000_2000) begin
      bad++; $display("FAIL contested_first: got gi/gd=%b addr=%h want 10 00002000", {gi, gd}, ad); end
    total++; if (seen !== 1) begin bad++; $display("FAIL contested_first_lat: got %0d want 1", seen); end
    txn(2, seen, gi, gd, rd, wr, ad, wd, ip, dp);
    total++; if ({gi, gd} !== 2'b01 || ad !== 32'h0000_3000) begin
      bad++; $display("FAIL contested_second: got gi/gd=%b addr=%h want 01 00003000", {gi, gd}, ad); end
    total++; if (seen !== 1) begin bad++; $display("FAIL contested_gap: got %0d want 1", seen); end
  endtask

  task automatic test_back_to_back();
    int seen, ip, dp; logic gi, gd, rd, wr; logic [31:0] ad; logic [255:0] wd;
    logic [1:0] order [4];
    order[0] = 2'b10; order[1] = 2'b01; order[2] = 2'b10; order[3] = 2'b01;
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2200;
    for (int k = 0; k < 4; k++) begin
      txn(1, seen, gi, gd, rd, wr, ad, wd, ip, dp);
      total++; if ({gi, gd} !== order[k]) begin
        bad++; $display("FAIL alternate_%0d: got gi/gd=%b want %b", k, {gi, gd}, order[k]); end
      if (gi) i_pmem_read = 1'b1;
      if (gd) d_pmem_read = 1'b1;
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
  endtask

  task automatic test_writeback_refill();
    int seen, ip, dp; logic gi, gd, rd, wr; logic [31:0] ad; logic [255:0] wd;
    logic [255:0] dline, iline;
    dline = {8{32'hC0DE_0A0A}};
    iline = {8{32'h1111_2222}};
    do_reset();
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_00A0; d_pmem_wdata = dline;
    i_pmem_wdata = iline;
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
    txn(3, seen, gi, gd, rd, wr, ad, wd, ip, dp);
    total++; if ({gd, wr, rd} !== 3'b110 || ad !== 32'h0000_00A0) begin
      bad++; $display("FAIL wb_first: got gd/wr/rd=%b addr=%h want 110 000000a0", {gd, wr, rd}, ad); end
    total++; if (wd !== dline) begin bad++; $display("FAIL wb_wdata: got %h want %h", wd, dline); end
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_00B0;
    txn(2, seen, gi, gd, rd, wr, ad, wd, ip, dp);
    total++; if ({gi, rd} !== 2'b11 || ad !== 32'h0000_2000) begin
      bad++; $display("FAIL wb_between: got gi/rd=%b addr=%h want 11 00002000", {gi, rd}, ad); end
    txn(2, seen, gi, gd, rd, wr, ad, wd, ip, dp);
    total++; if ({gd, rd} !== 2'b11 || ad !== 32'h0000_00B0) begin
      bad++; $display("FAIL wb_refill: got gd/rd=%b addr=%h want 11 000000b0", {gd, rd}, ad); end
  endtask

  task automatic test_drop_and_rdata();
    logic [255:0] line;
    line = {4{64'h0123_4567_89AB_CDEF}};
    do_reset();
    pmem_rdata = line;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_5000;
    d_pmem_read = 1'b0;
    #1;
    total++; if (i_pmem_rdata !== line || d_pmem_rdata !== line) begin
      bad++; $display("FAIL rdata_idle: got %h/%h want %h", i_pmem_rdata, d_pmem_rdata, line); end
    tick();
    i_pmem_read = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0 || dut.state !== SERVE_I) begin
      bad++; $display("FAIL drop_follow: got rd=%b state=%0d want 0/%0d", pmem_read, dut.state, SERVE_I); end
    tick();
    total++; if (dut.state !== SERVE_I) begin bad++; $display("FAIL drop_wait: got %0d want %0d", dut.state, SERVE_I); end
    pmem_resp = 1'b1;
    #1;
    total++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || d_pmem_rdata !== line) begin
      bad++; $display("FAIL drop_resp: got i=%b d=%b want 1/0", i_pmem_resp, d_pmem_resp); end
    tick();
    pmem_resp = 1'b0;
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL drop_idle: got %0d want %0d", dut.state, IDLE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_4000;
    tick();
    tick();
    total++; if (pmem_read !== 1'b1 || dut.state !== SERVE_D) begin
      bad++; $display("FAIL mid_serving: got rd=%b state=%0d want 1/%0d", pmem_read, dut.state, SERVE_D); end
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    total++; if (pmem_read !== 1'b0 || d_pmem_resp !== 1'b0) begin
      bad++; $display("FAIL mid_during_rst: got rd=%b dresp=%b want 0/0", pmem_read, d_pmem_resp); end
    tick();
    d_pmem_read = 1'b0;
    #1;
    total++; if (dut.state !== IDLE || dut.u_rr.last_i !== 1'b0 || pmem_read !== 1'b0 || d_pmem_resp !== 1'b0) begin
      bad++; $display("FAIL mid_after_rst: got state=%0d last_i=%b rd=%b dresp=%b want %0d/0/0/0",
                      dut.state, dut.u_rr.last_i, pmem_read, d_pmem_resp, IDLE); end
    rst = 1'b0; pmem_resp = 1'b0;
    tick();
    total++; if (dut.state !== IDLE || pmem_read !== 1'b0) begin
      bad++; $display("FAIL mid_released: got state=%0d rd=%b want %0d/0", dut.state, pmem_read, IDLE); end
  endtask

  task automatic test_idle_resp();
    do_reset();
    pmem_resp = 1'b1;
    #1;
    total++; if ({i_pmem_resp, d_pmem_resp, pmem_read, pmem_write} !== 4'b0000) begin
      bad++; $display("FAIL idle_resp: got %b want 0000", {i_pmem_resp, d_pmem_resp, pmem_read, pmem_write}); end
    tick();
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL idle_resp_state: got %0d want %0d", dut.state, IDLE); end
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6000;
    #1;
    total++; if (i_pmem_resp !== 1'b0) begin bad++; $display("FAIL idle_resp_with_req: got %b want 0", i_pmem_resp); end
    tick();
    pmem_resp = 1'b0;
    #1;
    total++; if (dut.state !== SERVE_I || pmem_address !== 32'h0000_6000 || i_pmem_resp !== 1'b0) begin
      bad++; $display("FAIL idle_resp_grant: got state=%0d addr=%h resp=%b want %0d 00006000 0",
                      dut.state, pmem_address, i_pmem_resp, SERVE_I); end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contested();
    test_back_to_back();
    test_writeback_refill();
    test_drop_and_rdata();
    test_reset_mid();
    test_idle_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 i_pmem_read  in  1  I-cache line-read request; held until i_pmem_resp.
REQ-004 i_pmem_write  in  1  I-cache line-write request; held until i_pmem_resp.
REQ-005 i_pmem_address  in  32  I-cache line address.
REQ-006 i_pmem_wdata  in  256  I-cache write line.
REQ-007 i_pmem_rdata  out  256  read line to I-cache.
REQ-008 i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
REQ-009 d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_rdata, d_pmem_resp: same widths and meanings as REQ-003..008, for the D-cache.
REQ-010 pmem_read  out  1  read request to cacheline adaptor.
REQ-011 pmem_write  out  1  write request to cacheline adaptor.
REQ-012 pmem_address  out  32  forwarded address.
REQ-013 pmem_wdata  out  256  forwarded write line.
REQ-014 pmem_rdata  in  256  adaptor read line.
REQ-015 pmem_resp  in  1  adaptor completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, SERVE_I, SERVE_D; a 1-bit register last_i records whether the I-cache won the most recent grant.
REQ-017 In IDLE, all pmem outputs SHALL be 0 and no requester resp SHALL assert.
REQ-018 In IDLE, a requester is pending when its read or write is 1; with only one pending, the next state SHALL serve it.
REQ-019 With both pending in IDLE, the next state SHALL be SERVE_D if last_i=1, else SERVE_I (round-robin); last_i SHALL update on entering the serve state.
REQ-020 In SERVE_x, pmem_read/write/address/wdata SHALL be driven combinationally from requester x only; the other requester's inputs SHALL be ignored.
REQ-021 In SERVE_x, x_pmem_resp SHALL equal pmem_resp; the non-granted resp SHALL be 0.
REQ-022 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata at all times (only resp qualifies).
REQ-023 On pmem_resp in SERVE_x, the next state SHALL be IDLE unconditionally; arbitration SHALL never occur in the same cycle as a resp, so a requester's stale request in the resp cycle is never re-granted.
REQ-024 Minimum overhead: one IDLE cycle between transactions; first pmem request SHALL appear the cycle after the request is seen in IDLE.
REQ-025 A cache write-back followed by refill SHALL be two independent grants; the other requester may be served between them.
REQ-026 If the granted requester drops its request before resp (illegal), outputs SHALL follow the inputs; the FSM SHALL still wait for pmem_resp.
REQ-027 Read and write asserted together by one requester is illegal; a simulation-only assertion SHALL fire, and forwarding SHALL be unchanged.
REQ-028 pmem_resp while in IDLE SHALL be ignored and SHALL not be forwarded.

Reset
REQ-029 On rst, state SHALL become IDLE and last_i SHALL become 0 on the next edge, so the first contested grant goes to the I-cache.
REQ-030 During and after reset all pmem_read/write and resp outputs SHALL be 0; address/wdata outputs SHALL be 0 in IDLE.
REQ-031 Reset mid-transaction SHALL abandon the grant with no resp pulse; the adaptor is reset by the same rst.

Structure
REQ-032 Package pmem_arb_pkg SHALL hold the state enum (IDLE, SERVE_I, SERVE_D) and the requester enum (REQ_I, REQ_D).
REQ-033 Output muxing SHALL be one always_comb on state; sub-module pmem_arb_rr (2-way round-robin picker holding last_i) is permitted.

Verification
REQ-034 Single I read at 0x0000_1000, resp after 5 cycles -> pmem_read the cycle after the request, i_pmem_resp one pulse, d_pmem_resp stays 0.
REQ-035 Both read in the same cycle after reset -> I served first, D served next with one IDLE cycle between.
REQ-036 Both held continuously for 4 transactions -> grants alternate I,D,I,D.
REQ-037 D write-back (0xA0) then read (0xB0) with I read pending -> order D-write, I-read, D-read; pmem_wdata matches d_pmem_wdata during the D write.
REQ-038 rst asserted 2 cycles into SERVE_D -> next cycle IDLE, pmem_read=0, no d_pmem_resp, last_i=0.
REQ-039 pmem_resp pulsed in IDLE -> no requester resp, state unchanged.
